// File: rtl/trace_capture_fifo_pkg.sv
// Shared constants, types and helpers for the trace capture FIFO.
package trace_pkg;

    localparam int unsigned WORD_W = 16;

    typedef enum logic {IDLE, SEND} ser_state_t;

    // Readout words per entry: one stamp word plus the trace words.
    function automatic int unsigned nwords(input int unsigned trace_w);
        return trace_w / WORD_W + 1;
    endfunction

endpackage

// File: rtl/trace_capture_fifo_if.sv
// Host read path: request pulse in, one 16-bit word per request out.
interface trace_capture_fifo_if;
    logic        r_rd_i;
    logic [15:0] r_q_16data_o;
    logic        r_dv_o;
    logic        r_last_o;
    logic        r_nodata_o;

    modport master (
        output r_rd_i,
        input  r_q_16data_o,
        input  r_dv_o,
        input  r_last_o,
        input  r_nodata_o
    );

    modport slave (
        input  r_rd_i,
        output r_q_16data_o,
        output r_dv_o,
        output r_last_o,
        output r_nodata_o
    );
endinterface

// File: rtl/trace_fifo_mem.sv
// Dual-pointer FIFO storage with occupancy count and registered full/empty flags.
module trace_fifo_mem #(
    parameter int unsigned DATA_W = 80,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk_ref,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, empty_q;
    logic              do_push, do_pop;

    // A full FIFO still accepts a push when an entry leaves in the same cycle.
    assign do_pop  = pop & ~clr & ~empty_q;
    assign do_push = push & ~clr & (~full_q | do_pop);

    always_comb begin
        count_d = count_q + (ADDR_W + 1)'(do_push) - (ADDR_W + 1)'(do_pop);
        if (clr) count_d = '0;
    end

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (clr) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            full_q  <= (count_d == (ADDR_W + 1)'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk_ref) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;
endmodule

// File: rtl/trace_capture_fifo.sv
// Captures stamped DUT output vectors into a FIFO and serialises them to the host as
// 16-bit words, one word per read request.
module trace_capture_fifo
    import trace_pkg::*;
#(
    parameter int unsigned TRACE_W = 64,
    parameter int unsigned ADDR_W  = 4
) (
    input  logic                 clk_ref,
    input  logic                 rst_n,
    input  logic                 run_verif_i,
    input  logic                 capt_trce_i,
    input  logic                 cycle_run_verif_i,
    input  logic [TRACE_W-1:0]   trace_i,
    input  logic                 r_clr_i,
    trace_capture_fifo_if.slave  rd,
    output logic                 fifo_full_o,
    output logic                 fifo_empty_o,
    output logic                 overflow_o,
    output logic [15:0]          lost_cnt_o
);
    localparam int unsigned NW      = nwords(TRACE_W);
    localparam int unsigned ENTRY_W = TRACE_W + WORD_W;
    localparam int unsigned IDX_W   = $clog2(NW);

    logic [WORD_W-1:0]  stamp_q, lost_q;
    logic               overflow_q;
    logic               push_req, pop, drop, rd_ok;
    logic               fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] fifo_rdata;

    ser_state_t         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ENTRY_W-1:0] hold_q, hold_d;
    logic [WORD_W-1:0]  data_q, data_d;
    logic               dv_q, dv_d, last_q, last_d, nodata_q, nodata_d;

    assign push_req = capt_trce_i & run_verif_i & ~r_clr_i;
    assign drop     = push_req & fifo_full & ~pop;
    // A request landing on the cycle a word is presented is ignored.
    assign rd_ok    = rd.r_rd_i & ~dv_q & ~r_clr_i;

    trace_fifo_mem #(
        .DATA_W (ENTRY_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk_ref (clk_ref),
        .rst_n   (rst_n),
        .clr     (r_clr_i),
        .push    (push_req),
        .pop     (pop),
        .wdata   ({stamp_q, trace_i}),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            stamp_q    <= '0;
            lost_q     <= '0;
            overflow_q <= 1'b0;
        end else if (r_clr_i) begin
            stamp_q    <= '0;
            lost_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (cycle_run_verif_i && run_verif_i) stamp_q <= stamp_q + 1'b1;
            if (drop) begin
                overflow_q <= 1'b1;
                if (lost_q != 16'hFFFF) lost_q <= lost_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        hold_d   = hold_q;
        data_d   = '0;
        dv_d     = 1'b0;
        last_d   = 1'b0;
        nodata_d = 1'b0;
        pop      = 1'b0;
        if (r_clr_i) begin
            state_d = IDLE;
            idx_d   = '0;
        end else if (rd_ok) begin
            unique case (state_q)
                IDLE: begin
                    dv_d = 1'b1;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        hold_d  = fifo_rdata;
                        data_d  = fifo_rdata[ENTRY_W-1 -: WORD_W];
                        idx_d   = IDX_W'(1);
                        state_d = SEND;
                    end else begin
                        nodata_d = 1'b1;
                    end
                end
                SEND: begin
                    dv_d   = 1'b1;
                    data_d = WORD_W'(hold_q >> (WORD_W * (int'(idx_q) - 1)));
                    if (idx_q == IDX_W'(NW - 1)) begin
                        last_d  = 1'b1;
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            hold_q   <= '0;
            data_q   <= '0;
            dv_q     <= 1'b0;
            last_q   <= 1'b0;
            nodata_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            hold_q   <= hold_d;
            data_q   <= data_d;
            dv_q     <= dv_d;
            last_q   <= last_d;
            nodata_q <= nodata_d;
        end
    end

    assign rd.r_q_16data_o = data_q;
    assign rd.r_dv_o       = dv_q;
    assign rd.r_last_o     = last_q;
    assign rd.r_nodata_o   = nodata_q;
    assign fifo_full_o     = fifo_full;
    assign fifo_empty_o    = fifo_empty;
    assign overflow_o      = overflow_q;
    assign lost_cnt_o      = lost_q;
endmodule

// File: tb/tb_trace_capture_fifo.sv
// Randomised and directed bench for trace_capture_fifo against a queue-based reference model.
module tb_trace_capture_fifo;
    logic        clk_ref = 1'b0;
    logic        rst_n;
    logic        run_verif, capt_trce, cycle_run, r_clr;
    logic [63:0] trace;
    logic        fifo_full, fifo_empty, overflow;
    logic [15:0] lost_cnt;

    trace_capture_fifo_if rd_if ();

    trace_capture_fifo #(
        .TRACE_W (64),
        .ADDR_W  (4)
    ) dut (
        .clk_ref           (clk_ref),
        .rst_n             (rst_n),
        .run_verif_i       (run_verif),
        .capt_trce_i       (capt_trce),
        .cycle_run_verif_i (cycle_run),
        .trace_i           (trace),
        .r_clr_i           (r_clr),
        .rd                (rd_if),
        .fifo_full_o       (fifo_full),
        .fifo_empty_o      (fifo_empty),
        .overflow_o        (overflow),
        .lost_cnt_o        (lost_cnt)
    );

    always #5 clk_ref = ~clk_ref;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: stored entries, pending readout words and counters.
    logic [79:0] m_q[$];
    logic [15:0] m_words[$];
    logic [15:0] m_stamp, m_lost;
    bit          m_ovf;
    bit          e_dv, e_last, e_nodata;
    logic [15:0] e_data;

    task automatic model_reset();
        m_q.delete();
        m_words.delete();
        m_stamp  = '0;
        m_lost   = '0;
        m_ovf    = 0;
        e_dv     = 0;
        e_last   = 0;
        e_nodata = 0;
        e_data   = '0;
    endtask

    task automatic model_step(input bit run_v, capt_v, cyc_v, clr_v, rd_v,
                              input logic [63:0] tr);
        bit          rd_ok, n_dv, n_last, n_nodata;
        logic [15:0] n_data;
        logic [79:0] ent;
        rd_ok    = rd_v && !e_dv;
        n_dv     = 0;
        n_last   = 0;
        n_nodata = 0;
        n_data   = '0;
        if (clr_v) begin
            model_reset();
            return;
        end
        if (rd_ok) begin
            if (m_words.size() == 0 && m_q.size() > 0) begin
                ent = m_q.pop_front();
                m_words.push_back(ent[79:64]);
                for (int k = 0; k < 4; k++) m_words.push_back(ent[16*k +: 16]);
            end
            n_dv = 1;
            if (m_words.size() > 0) begin
                n_data = m_words.pop_front();
                n_last = (m_words.size() == 0);
            end else begin
                n_nodata = 1;
            end
        end
        if (capt_v && run_v) begin
            if (m_q.size() < 16) begin
                m_q.push_back({m_stamp, tr});
            end else begin
                m_ovf = 1;
                if (m_lost != 16'hFFFF) m_lost = m_lost + 16'd1;
            end
        end
        if (cyc_v && run_v) m_stamp = m_stamp + 16'd1;
        e_dv     = n_dv;
        e_last   = n_last;
        e_nodata = n_nodata;
        e_data   = n_data;
    endtask

    task automatic check_all();
        check_eq("r_dv", 32'(rd_if.r_dv_o), 32'(e_dv));
        check_eq("r_data", 32'(rd_if.r_q_16data_o), 32'(e_data));
        check_eq("r_last", 32'(rd_if.r_last_o), 32'(e_last));
        check_eq("r_nodata", 32'(rd_if.r_nodata_o), 32'(e_nodata));
        check_eq("full", 32'(fifo_full), 32'(m_q.size() == 16));
        check_eq("empty", 32'(fifo_empty), 32'(m_q.size() == 0));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        check_eq("lost_cnt", 32'(lost_cnt), 32'(m_lost));
    endtask

    task automatic check_reset_vals();
        check_eq("rst_dv", 32'(rd_if.r_dv_o), 0);
        check_eq("rst_data", 32'(rd_if.r_q_16data_o), 0);
        check_eq("rst_last", 32'(rd_if.r_last_o), 0);
        check_eq("rst_nodata", 32'(rd_if.r_nodata_o), 0);
        check_eq("rst_full", 32'(fifo_full), 0);
        check_eq("rst_empty", 32'(fifo_empty), 1);
        check_eq("rst_overflow", 32'(overflow), 0);
        check_eq("rst_lost", 32'(lost_cnt), 0);
    endtask

    task automatic tick(input bit run_v, capt_v, cyc_v, clr_v, rd_v, input logic [63:0] tr);
        run_verif    = run_v;
        capt_trce    = capt_v;
        cycle_run    = cyc_v;
        r_clr        = clr_v;
        rd_if.r_rd_i = rd_v;
        trace        = tr;
        @(posedge clk_ref);
        model_step(run_v, capt_v, cyc_v, clr_v, rd_v, tr);
        #1;
        check_all();
    endtask

    task automatic idle();
        tick(1, 0, 0, 0, 0, 64'h0);
    endtask

    task automatic read_word(output logic [15:0] w, output bit l);
        tick(1, 0, 0, 0, 1, 64'h0);
        w = rd_if.r_q_16data_o;
        l = rd_if.r_last_o;
        idle();
    endtask

    task automatic capture(input logic [63:0] tr);
        tick(1, 1, 0, 0, 0, tr);
    endtask

    logic [15:0] w;
    bit          l;
    logic [15:0] exp_w [5];

    initial begin
        rst_n        = 1'b0;
        run_verif    = 0;
        capt_trce    = 0;
        cycle_run    = 0;
        r_clr        = 0;
        rd_if.r_rd_i = 0;
        trace        = '0;
        model_reset();
        #12;
        check_reset_vals();
        @(negedge clk_ref);
        rst_n = 1'b1;

        // Empty read returns a nodata word.
        tick(0, 0, 0, 0, 1, 64'h0);
        check_eq("empty_rd_nodata", 32'(rd_if.r_nodata_o), 1);
        idle();

        // Three cycle pulses, then one capture and a full entry readout.
        repeat (3) tick(1, 0, 1, 0, 0, 64'h0);
        capture(64'h0123_4567_89AB_CDEF);
        exp_w[0] = 16'h0003; exp_w[1] = 16'hCDEF; exp_w[2] = 16'h89AB;
        exp_w[3] = 16'h4567; exp_w[4] = 16'h0123;
        for (int i = 0; i < 5; i++) begin
            read_word(w, l);
            check_eq($sformatf("entry_word%0d", i), 32'(w), 32'(exp_w[i]));
            check_eq($sformatf("entry_last%0d", i), 32'(l), (i == 4) ? 1 : 0);
        end

        // Overfill: 18 captures into 16 entries.
        tick(1, 0, 0, 1, 0, 64'h0);
        for (int i = 0; i < 18; i++) tick(1, 1, 1, 0, 0, {$urandom, $urandom});
        check_eq("ovf_full", 32'(fifo_full), 1);
        check_eq("ovf_flag", 32'(overflow), 1);
        check_eq("ovf_lost", 32'(lost_cnt), 2);

        // Capture coinciding with an IDLE pop on a full FIFO is accepted.
        tick(1, 1, 0, 0, 1, 64'hFEED_FACE_CAFE_BEEF);
        check_eq("coinc_word0", 32'(rd_if.r_q_16data_o), 0);
        idle();
        check_eq("coinc_lost", 32'(lost_cnt), 2);
        check_eq("coinc_full", 32'(fifo_full), 1);
        for (int i = 0; i < 4; i++) read_word(w, l);
        for (int e = 0; e < 16; e++) begin
            read_word(w, l);
            check_eq($sformatf("drain_stamp%0d", e), 32'(w), (e < 15) ? e + 1 : 18);
            for (int i = 0; i < 4; i++) read_word(w, l);
        end
        check_eq("drained_empty", 32'(fifo_empty), 1);

        // Stamp wrap and capture coinciding with an increment.
        tick(1, 0, 0, 1, 0, 64'h0);
        for (int i = 0; i < 65535; i++) tick(1, 0, 1, 0, 0, 64'h0);
        tick(1, 1, 1, 0, 0, 64'h1111_2222_3333_4444);
        capture(64'h5555_6666_7777_8888);
        read_word(w, l);
        check_eq("stamp_preinc", 32'(w), 32'hFFFF);
        for (int i = 0; i < 4; i++) read_word(w, l);
        read_word(w, l);
        check_eq("stamp_wrap", 32'(w), 0);
        for (int i = 0; i < 4; i++) read_word(w, l);

        // Flush in the middle of an entry readout.
        for (int i = 0; i < 17; i++) capture({$urandom, $urandom});
        read_word(w, l);
        read_word(w, l);
        tick(1, 1, 1, 1, 1, 64'h0);
        check_eq("clr_dv", 32'(rd_if.r_dv_o), 0);
        check_eq("clr_empty", 32'(fifo_empty), 1);
        check_eq("clr_lost", 32'(lost_cnt), 0);
        tick(1, 0, 0, 0, 1, 64'h0);
        check_eq("clr_idle_nodata", 32'(rd_if.r_nodata_o), 1);
        idle();

        // Asynchronous reset in the middle of an entry readout.
        for (int i = 0; i < 17; i++) capture({$urandom, $urandom});
        read_word(w, l);
        tick(1, 0, 0, 0, 1, 64'h0);
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        model_reset();
        rd_if.r_rd_i = 0;
        capt_trce    = 0;
        @(negedge clk_ref);
        rst_n = 1'b1;
        tick(1, 0, 0, 0, 1, 64'h0);
        check_eq("rst_idle_nodata", 32'(rd_if.r_nodata_o), 1);
        idle();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 3,
                 $urandom_range(0, 9) < 3, $urandom_range(0, 49) == 0,
                 $urandom_range(0, 9) < 4, {$urandom, $urandom});
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/trace_capture_fifo.md
Name: trace_capture_fifo

Overview:
- Downstream consumer of the user-clock generator's capture strobe (capt_trce) and cycle strobe (cycle_run_verif).
- On each capture strobe during a verification run, samples the DUT output vector and tags it with a 16-bit cycle stamp.
- Buffers tagged entries in a FIFO and serialises them as 16-bit words to the host read path, one word per request.

Parameters:
- TRACE_W, 64: DUT output vector width; must be a multiple of 16, range 16..256.
- ADDR_W, 4: FIFO address width; depth = 2**ADDR_W entries.

Ports:
- clk_ref  in  1  reference clock (single clock domain).
- rst_n  in  1  asynchronous active-low reset.
- run_verif_i  in  1  verification run active.
- capt_trce_i  in  1  capture strobe, one clk_ref cycle per capture edge.
- cycle_run_verif_i  in  1  user-cycle strobe; advances the stamp counter.
- trace_i  in  TRACE_W  DUT outputs, already stable at clk_ref.
- r_clr_i  in  1  synchronous flush of FIFO, stamp counter and loss counter.
- r_rd_i  in  1  host read request, single-cycle pulse.
- r_q_16data_o  out  16  read data.
- r_dv_o  out  1  read data valid, one-cycle pulse.
- r_last_o  out  1  qualifies r_dv_o on the final word of an entry.
- r_nodata_o  out  1  qualifies r_dv_o when no entry was available.
- fifo_full_o  out  1  FIFO holds 2**ADDR_W entries.
- fifo_empty_o  out  1  FIFO holds 0 entries.
- overflow_o  out  1  sticky: at least one capture dropped.
- lost_cnt_o  out  16  dropped captures; saturates at 16'hFFFF.

Behaviour:
- Reset values: all outputs 0, except fifo_empty_o = 1. Reset also returns the serialiser to IDLE, zeroes the pointers and the stamp counter. Reset takes effect mid-readout without completing the entry.
- Stamp counter (16 bit):
  - increments on cycle_run_verif_i & run_verif_i;
  - wraps 16'hFFFF -> 16'h0000;
  - a capture in the same cycle as an increment records the pre-increment value.
- Push:
  - condition: capt_trce_i & run_verif_i & !r_clr_i;
  - entry = {stamp, trace_i}, written at the write pointer;
  - if full and no pop in the same cycle: entry dropped, overflow_o <= 1, lost_cnt_o += 1 (saturating);
  - if full with a pop in the same cycle: push accepted.
- Entry readout is NW = TRACE_W/16 + 1 words:
  - word 0 = stamp;
  - words 1..NW-1 = trace_i[15:0], [31:16], … up to the MSW.
- Serialiser FSM:
  - IDLE: on r_rd_i,
    - if FIFO not empty: pop the entry into the holding register, drive word 0 next cycle with r_dv_o = 1, go to SEND with index = 1;
    - if FIFO empty: next cycle r_dv_o = 1, r_nodata_o = 1, data 16'h0000, stay IDLE.
  - SEND: on each r_rd_i, drive word[index] next cycle with r_dv_o = 1. When index = NW-1, also assert r_last_o and return to IDLE.
  - Read latency is exactly 1 cycle from r_rd_i to r_dv_o.
  - r_rd_i must not be asserted on the cycle r_dv_o is high; if it is, the request is ignored.
- Flags: occupancy count is ADDR_W+1 bits; pointers wrap modulo depth; fifo_full_o and fifo_empty_o are registered from the updated count.
- r_clr_i:
  - priority over push, pop and read;
  - empties the FIFO, zeroes the stamp counter, clears overflow_o and lost_cnt_o, forces IDLE;
  - r_dv_o is 0 in the cycle after r_clr_i.
- run_verif_i low blocks capture and the stamp count; readout continues, so the host drains after a run.

Decomposition:
- Package trace_pkg holds:
  - constant WORD_W = 16;
  - function nwords(TRACE_W) = TRACE_W/16 + 1;
  - enum ser_state_t {IDLE, SEND}.
- One sub-module, trace_fifo_mem: parameterised dual-pointer RAM with count, full and empty.
- The serialiser and stamp/loss logic stay in the top module.

Test Plan:
- Reset then r_rd_i with FIFO empty -> 1 cycle later r_dv_o = 1, r_nodata_o = 1, data 0000, fifo_empty_o = 1.
- run_verif_i = 1; 3 cycle_run_verif_i pulses; capture with trace_i = 64'h0123_4567_89AB_CDEF; then 5 reads:
  - words = 0003, CDEF, 89AB, 4567, 0123;
  - r_last_o on the 5th word only.
- 18 captures into 16-deep FIFO, no reads -> fifo_full_o = 1, overflow_o = 1, lost_cnt_o = 2; the first 16 entries read back in order with stamps intact.
- FIFO full; capture coinciding with the IDLE pop -> entry accepted, lost_cnt_o unchanged, count stays 16.
- Stamp at 16'hFFFF plus one more cycle pulse, then capture -> stamp word = 0000. Capture and cycle pulse in the same cycle -> pre-increment stamp recorded.
- r_clr_i during SEND at index 2 -> next cycle r_dv_o = 0, FSM IDLE, fifo_empty_o = 1, lost_cnt_o = 0. Separately, assert rst_n low mid-SEND -> all outputs at reset values.
